// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the unified memory-port arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IMEM_BUSY = 2'd1,
    DMEM_BUSY = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IMEM = 2'b01,
    OWN_DMEM = 2'b10
  } owner_e;

  // Bits needed to hold values 0..max_val inclusive (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_bus_timeout_counter.sv
// Wait-state counter: counts enabled cycles and flags expiry on the
// cycle the count reaches limit_i-1. A limit of zero never expires.
module bus_timeout_counter
  import mem_bus_pkg::*;
#(
  parameter int unsigned MAX_LIMIT = 16,
  localparam int unsigned CNT_W    = cnt_width(MAX_LIMIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_limit;

  assign at_limit = (limit_i != '0) && (cnt_q == (limit_i - ONE));
  assign expire_o = enable_i && at_limit;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !at_limit) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Registered imem/dmem arbiter for the single memory port: dmem priority
// with a fetch starvation guard, fields latched at grant, wait-state timeout.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned DMEM_STREAK_MAX = 4,
  localparam int unsigned STRB_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_ready,
  output logic              imem_err,
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [STRB_W-1:0] dmem_wstrb,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_ready,
  output logic              dmem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        bus_owner
);

  localparam int unsigned TO_W   = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned STK_W  = cnt_width(DMEM_STREAK_MAX);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(DMEM_STREAK_MAX);
  localparam logic [STK_W-1:0] STK_ONE  = STK_W'(1);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [STK_W-1:0]  streak_q, streak_d;

  logic   imem_busy, dmem_busy, busy;
  logic   dmem_wins;
  logic   expire;
  owner_e owner;

  assign imem_busy = (state_q == IMEM_BUSY);
  assign dmem_busy = (state_q == DMEM_BUSY);
  assign busy      = imem_busy || dmem_busy;
  assign dmem_wins = dmem_req && (!imem_req || (streak_q < STK_MAX));

  bus_timeout_counter #(
    .MAX_LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q == IDLE),
    .enable_i (busy && !mem_ready),
    .limit_i  (TO_LIMIT),
    .expire_o (expire)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    streak_d    = streak_q;
    unique case (state_q)
      IDLE: begin
        if (!imem_req) begin
          streak_d = '0;
        end
        if (dmem_wins) begin
          state_d     = DMEM_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dmem_we;
          mem_addr_d  = dmem_addr;
          mem_wdata_d = dmem_wdata;
          mem_wstrb_d = dmem_we ? dmem_wstrb : '0;
          if (imem_req && (streak_q != STK_MAX)) begin
            streak_d = streak_q + STK_ONE;
          end
        end else if (imem_req) begin
          state_d     = IMEM_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = imem_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          streak_d    = '0;
        end
      end
      IMEM_BUSY, DMEM_BUSY: begin
        // expire is already suppressed when mem_ready is high, so a
        // coincident response completes normally.
        if (mem_ready || expire) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      streak_q    <= streak_d;
    end
  end

  always_comb begin
    unique case (state_q)
      IMEM_BUSY: owner = OWN_IMEM;
      DMEM_BUSY: owner = OWN_DMEM;
      default:   owner = OWN_NONE;
    endcase
  end

  assign imem_ready = imem_busy && mem_ready;
  assign dmem_ready = dmem_busy && mem_ready;
  assign imem_err   = imem_busy && expire;
  assign dmem_err   = dmem_busy && expire;
  assign imem_rdata = imem_ready ? mem_rdata : '0;
  assign dmem_rdata = dmem_ready ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign bus_owner = owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single transactions plus
// hand-written arbitration, starvation, timeout, race and reset sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready, imem_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready, dmem_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [1:0]  bus_owner;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .TIMEOUT_CYCLES  (16),
    .DMEM_STREAK_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .imem_err   (imem_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .dmem_err   (dmem_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .bus_owner  (bus_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic own_ready(input bit d);
    return d ? dmem_ready : imem_ready;
  endfunction

  function automatic logic oth_ready(input bit d);
    return d ? imem_ready : dmem_ready;
  endfunction

  function automatic logic own_err(input bit d);
    return d ? dmem_err : imem_err;
  endfunction

  function automatic logic [31:0] own_rdata(input bit d);
    return d ? dmem_rdata : imem_rdata;
  endfunction

  task automatic run_txn(input vec_t v);
    if (v.is_d) begin
      dmem_req = 1'b1; dmem_we = v.we; dmem_addr = v.addr;
      dmem_wdata = v.wdata; dmem_wstrb = v.wstrb;
    end else begin
      imem_req = 1'b1; imem_addr = v.addr;
    end
    tick();
    chk("grant_mem_req", 32'(mem_req), 32'd1);
    chk("grant_mem_addr", mem_addr, v.addr);
    chk("grant_mem_we", 32'(mem_we), 32'(v.we));
    chk("grant_mem_wstrb", 32'(mem_wstrb), 32'(v.exp_wstrb));
    chk("grant_mem_wdata", mem_wdata, v.exp_wdata);
    chk("grant_owner", 32'(bus_owner), 32'(v.exp_owner));
    imem_addr = ~v.addr; dmem_addr = ~v.addr; dmem_wdata = ~v.wdata;
    mem_rdata = 32'h5555AAAA;
    for (int k = 0; k < v.lat; k++) begin
      #1;
      chk("busy_ready_low", 32'(own_ready(v.is_d)), 32'd0);
      chk("busy_rdata_masked", own_rdata(v.is_d), 32'd0);
      chk("busy_addr_held", mem_addr, v.addr);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = v.rdata;
    #1;
    chk("done_ready", 32'(own_ready(v.is_d)), 32'd1);
    chk("done_rdata", own_rdata(v.is_d), v.rdata);
    chk("done_other_ready", 32'(oth_ready(v.is_d)), 32'd0);
    chk("done_err", 32'(own_err(v.is_d)), 32'd0);
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0BADF00D;
    imem_req = 1'b0; dmem_req = 1'b0;
    chk("after_mem_req", 32'(mem_req), 32'd0);
    chk("after_owner", 32'(bus_owner), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] starve_exp [7];

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 32'hDEADBEEF, 4'h0, 32'h0, 2'b01};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h12345678, 4'hF, 0, 32'h0, 4'hF, 32'h12345678, 2'b10};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0, 4'hF, 1, 32'hCAFEF00D, 4'h0, 32'h0, 2'b10};
    vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hA5A5A5A5, 4'h3, 0, 32'h0, 4'h3, 32'hA5A5A5A5, 2'b10};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 5, 32'h00000000, 4'h0, 32'h0, 2'b01};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 14, 32'h00000001, 4'h0, 32'h0, 2'b10};
    starve_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};

    rst_n = 1'b0;
    imem_req = 1'b0; imem_addr = 32'h0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_addr = 32'h0;
    dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_owner", 32'(bus_owner), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
    chk("rst_readys", {30'd0, imem_ready, dmem_ready}, 32'd0);
    chk("rst_errs", {30'd0, imem_err, dmem_err}, 32'd0);
    chk("rst_imem_rdata", imem_rdata, 32'd0);
    chk("rst_dmem_rdata", dmem_rdata, 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i]);
    end

    // Simultaneous requests: dmem store first, fetch after one IDLE cycle.
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h2000;
    dmem_wdata = 32'h12345678; dmem_wstrb = 4'hF;
    imem_req = 1'b1; imem_addr = 32'h104;
    tick();
    chk("sim_owner_d", 32'(bus_owner), 32'd2);
    chk("sim_we", 32'(mem_we), 32'd1);
    chk("sim_wstrb", 32'(mem_wstrb), 32'hF);
    chk("sim_addr_d", mem_addr, 32'h2000);
    mem_ready = 1'b1; mem_rdata = 32'h0;
    #1;
    chk("sim_dmem_ready", 32'(dmem_ready), 32'd1);
    chk("sim_imem_ready_low", 32'(imem_ready), 32'd0);
    tick();
    mem_ready = 1'b0; dmem_req = 1'b0;
    chk("sim_gap_owner", 32'(bus_owner), 32'd0);
    chk("sim_gap_req", 32'(mem_req), 32'd0);
    tick();
    chk("sim_owner_i", 32'(bus_owner), 32'd1);
    chk("sim_addr_i", mem_addr, 32'h104);
    chk("sim_fetch_we_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
    chk("sim_fetch_wdata", mem_wdata, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h13579BDF;
    #1;
    chk("sim_imem_rdata", imem_rdata, 32'h13579BDF);
    tick();
    mem_ready = 1'b0; imem_req = 1'b0;
    tick();

    // Starvation guard: both held high, four dmem grants then one fetch.
    imem_req = 1'b1; imem_addr = 32'h200;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h3000; dmem_wstrb = 4'h0;
    for (int g = 0; g < 7; g++) begin
      tick();
      chk($sformatf("starve_owner_%0d", g), 32'(bus_owner), 32'(starve_exp[g]));
      mem_ready = 1'b1; mem_rdata = 32'(g);
      #1;
      chk($sformatf("starve_ready_%0d", g), 32'(own_ready(starve_exp[g] == 2'b10)), 32'd1);
      tick();
      mem_ready = 1'b0;
      chk($sformatf("starve_gap_%0d", g), 32'(bus_owner), 32'd0);
    end
    imem_req = 1'b0; dmem_req = 1'b0;
    tick();

    // Timeout: dmem load never answered, err on busy cycle 16.
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h40;
    tick();
    for (int c = 1; c <= 15; c++) begin
      chk($sformatf("to_no_err_c%0d", c), 32'(dmem_err), 32'd0);
      tick();
    end
    chk("to_err", 32'(dmem_err), 32'd1);
    chk("to_ready_low", 32'(dmem_ready), 32'd0);
    chk("to_imem_err_low", 32'(imem_err), 32'd0);
    tick();
    dmem_req = 1'b0;
    chk("to_after_req", 32'(mem_req), 32'd0);
    chk("to_after_owner", 32'(bus_owner), 32'd0);

    // Race: mem_ready on the timeout cycle wins.
    imem_req = 1'b1; imem_addr = 32'h80;
    tick();
    for (int c = 1; c <= 15; c++) tick();
    mem_ready = 1'b1; mem_rdata = 32'h77778888;
    #1;
    chk("race_ready", 32'(imem_ready), 32'd1);
    chk("race_err", 32'(imem_err), 32'd0);
    chk("race_rdata", imem_rdata, 32'h77778888);
    tick();
    mem_ready = 1'b0; imem_req = 1'b0;
    chk("race_after_req", 32'(mem_req), 32'd0);

    // Reset mid-transaction, then a fresh grant of the still-pending fetch.
    imem_req = 1'b1; imem_addr = 32'h500;
    tick();
    chk("rmid_granted", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_req_drop", 32'(mem_req), 32'd0);
    chk("rmid_owner", 32'(bus_owner), 32'd0);
    chk("rmid_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_addr = 32'h600;
    tick();
    chk("rmid_regrant_owner", 32'(bus_owner), 32'd1);
    chk("rmid_regrant_addr", mem_addr, 32'h600);
    mem_ready = 1'b1; mem_rdata = 32'hA0A0A0A0;
    #1;
    chk("rmid_ready", 32'(imem_ready), 32'd1);
    tick();
    mem_ready = 1'b0; imem_req = 1'b0;
    chk("rmid_after_req", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Registered arbiter that shares the single unified memory port between the instruction-fetch (imem) and load/store (dmem) requesters of the core. It replaces level-select address steering with a request/ready handshake and a three-state sequencer. Transaction fields are latched at grant. Dmem has priority, with a starvation guard for fetch. A wait-state timeout returns an error when memory never answers.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width; strobe width is DATA_W/8
TIMEOUT_CYCLES, 16, max busy cycles without mem_ready before abort; 0 disables timeout
DMEM_STREAK_MAX, 4, max consecutive dmem grants while imem_req is pending

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  input  1  fetch request, held high until imem_ready or imem_err
imem_addr  input  ADDR_W  fetch address
imem_rdata  output  DATA_W  fetch data, valid only while imem_ready=1
imem_ready  output  1  fetch completion pulse
imem_err  output  1  fetch timeout pulse
dmem_req  input  1  load/store request, held until dmem_ready or dmem_err
dmem_we  input  1  1=store, 0=load
dmem_addr  input  ADDR_W  load/store address
dmem_wdata  input  DATA_W  store data
dmem_wstrb  input  DATA_W/8  store byte enables
dmem_rdata  output  DATA_W  load data, valid only while dmem_ready=1
dmem_ready  output  1  load/store completion pulse
dmem_err  output  1  load/store timeout pulse
mem_req  output  1  registered request to memory
mem_we  output  1  registered write enable
mem_addr  output  ADDR_W  registered address
mem_wdata  output  DATA_W  registered store data
mem_wstrb  output  DATA_W/8  registered strobes (0 for fetch and loads)
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
mem_ready  input  1  memory completion pulse
bus_owner  output  2  00 idle, 01 imem, 10 dmem

Behaviour:
- Reset (async assert): state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, bus_owner, streak and timeout counters all 0. Ready, err and rdata outputs read 0. Mid-transaction reset drops mem_req immediately; the in-flight response is discarded.
- States: IDLE, IMEM_BUSY, DMEM_BUSY.
- IDLE: if neither req is high, stay. Grant dmem if dmem_req and (not imem_req or streak<DMEM_STREAK_MAX); otherwise grant imem if imem_req. At the grant edge: load mem_addr/mem_we/mem_wdata/mem_wstrb from the winner (imem: we=0, wstrb=0, wdata=0), set mem_req=1, clear the timeout counter, move to the matching BUSY state.
- Streak: incremented on a dmem grant while imem_req=1, saturating. Cleared on any imem grant, or in IDLE when imem_req=0.
- BUSY: mem_* held stable. The owner's ready = mem_ready (combinational) and its rdata = mem_rdata masked by mem_ready. The non-owner's ready, err and rdata read 0. On mem_ready: next state IDLE, mem_req=0 at that edge.
- Timeout: the counter increments each BUSY cycle without mem_ready. When it reaches TIMEOUT_CYCLES-1 and mem_ready=0, the owner's err pulses high that cycle (ready stays 0), then next state is IDLE with mem_req=0. If mem_ready and the timeout coincide, mem_ready wins (normal completion, no err).
- Requesters drop req on the edge where they see ready/err. A req high in IDLE is always a new request.
- Minimum transaction = 2 cycles (grant edge, then mem_ready). There is always one IDLE cycle between transactions, with mem_req low for at least one cycle.
- Requests deasserted while not granted are legal and simply not served. Changing address/data of an ungranted requester is legal. Changing them after grant has no effect.

Decomposition:
- Package mem_bus_pkg: state enum (IDLE/IMEM_BUSY/DMEM_BUSY), bus_owner encodings (OWN_NONE/OWN_IMEM/OWN_DMEM), counter width function (clog2-based).
- One sub-module, bus_timeout_counter: clear/enable/limit inputs, expire output, disabled when the limit is 0.

Test Plan:
- Single fetch: imem_req=1, addr=0x100, mem_ready 3 cycles after mem_req with rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, imem_ready one cycle with imem_rdata=0xDEADBEEF, dmem_ready=0, bus_owner 01 then 00.
- Simultaneous req, dmem store addr=0x2000, wdata=0x12345678, wstrb=0xF -> dmem granted first (mem_we=1, mem_wstrb=0xF); imem granted after one IDLE cycle.
- Starvation: dmem_req and imem_req held high, memory ready 1 cycle after request -> exactly 4 dmem grants, then 1 imem grant, then dmem resumes.
- Timeout: dmem load, mem_ready never asserted, TIMEOUT_CYCLES=16 -> dmem_err pulses on busy cycle 16, dmem_ready=0, mem_req low the next cycle, state IDLE.
- Race: mem_ready asserts on the same cycle the timeout expires -> ready=1, err=0.
- Reset mid-transaction: rst_n low during IMEM_BUSY -> mem_req=0 and bus_owner=00 without a clock edge. After release, a pending req is granted fresh.
